// File: rtl/um_egress_pkg.sv
// um_egress_pkg: flit tags, default flit width and FSM states shared by the UM egress arbiter
package um_egress_pkg;
  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b00;
  localparam logic [1:0] TAG_TAIL = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;
  localparam int DATA_W_DEF = 134;
  typedef enum logic {IDLE_S, SEND_S} state_t;
  function automatic logic is_tail(input logic [1:0] tag);
    return tag == TAG_TAIL || tag == TAG_SINGLE;
  endfunction
endpackage

// File: rtl/um_rr_arbiter.sv
// um_rr_arbiter: fixed-priority (highest index) or round-robin one-hot grant; pointer moves per packet
module um_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ARB_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          req,
  input  logic                       upd,
  input  logic [$clog2(NUM_CH)-1:0]  upd_ptr,
  output logic [NUM_CH-1:0]          grant
);
  localparam int IW = $clog2(NUM_CH);
  logic [IW-1:0] ptr;
  // later iterations override earlier ones, so the last match is the winner
  always_comb begin
    grant = '0;
    for (int k = NUM_CH; k >= 1; k--)
      for (int i = 0; i < NUM_CH; i++)
        if (req[i] && (ARB_MODE == 0 ? i == NUM_CH - k : i == (int'(ptr) + k) % NUM_CH))
          grant = NUM_CH'(1) << i;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= IW'(NUM_CH - 1);
    else if (upd) ptr <= upd_ptr;
endmodule

// File: rtl/um_egress_arb.sv
// um_egress_arb: packet-atomic NUM_CH:1 merge of show-ahead FIFOs onto the UM pktout port.
// Define UM_EGRESS_CNT_EN to add per-channel forwarded-packet counters on pkt_cnt.
module um_egress_arb import um_egress_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ARB_MODE = 1,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic [NUM_CH-1:0]          in_empty,
  output logic [NUM_CH-1:0]          in_rdreq,
  output logic                       pktout_data_wr,
  output logic [DATA_W-1:0]          pktout_data,
  output logic                       pktout_data_valid,
  output logic                       pktout_data_valid_wr,
  input  logic                       pktout_ready
`ifdef UM_EGRESS_CNT_EN
  , output logic [NUM_CH*CNT_W-1:0]  pkt_cnt
`endif
);
  localparam int IW = $clog2(NUM_CH);
  state_t state, state_nxt;
  logic [NUM_CH-1:0] gnt, gnt_nxt, arb_gnt, req;
  logic [IW-1:0] gidx;
  logic [DATA_W-1:0] sel;
  logic pop, tail;
  assign req = ~in_empty;
  assign in_rdreq = (state == SEND_S && pktout_ready) ? gnt & req : '0;
  assign pop = |in_rdreq;
  assign tail = pop && is_tail(sel[DATA_W-1 -: 2]);
  always_comb begin
    sel = '0;
    gidx = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (gnt[k]) begin
        sel = in_data[k*DATA_W +: DATA_W];
        gidx = IW'(k);
      end
  end
  um_rr_arbiter #(.NUM_CH(NUM_CH), .ARB_MODE(ARB_MODE)) u_arb (
    .clk(clk), .rst_n(rst_n), .req(req), .upd(tail), .upd_ptr(gidx), .grant(arb_gnt)
  );
  // grant is only sampled in IDLE and then held until the tail pops
  always_comb begin
    state_nxt = state == IDLE_S ? ((|req && pktout_ready) ? SEND_S : IDLE_S) : (tail ? IDLE_S : SEND_S);
    gnt_nxt = (state == IDLE_S && |req && pktout_ready) ? arb_gnt : gnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE_S;
      gnt <= '0;
      pktout_data_wr <= 1'b0;
      pktout_data <= '0;
      pktout_data_valid <= 1'b0;
      pktout_data_valid_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt <= gnt_nxt;
      pktout_data_wr <= pop;
      pktout_data_valid_wr <= tail;
      if (pop) pktout_data <= sel;
      if (tail) pktout_data_valid <= 1'b1;
    end
`ifdef UM_EGRESS_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pkt_cnt <= '0;
    else
      for (int k = 0; k < NUM_CH; k++)
        if (tail && gnt[k]) pkt_cnt[k*CNT_W +: CNT_W] <= pkt_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
`else
  logic [CNT_W-1:0] cnt_unused;
  assign cnt_unused = '0;
`endif
endmodule

// File: tb/tb_um_egress_arb.sv
// tb_um_egress_arb: directed checks of um_egress_arb, fixed-priority (2 ch) and round-robin (4 ch) instances
module tb_um_egress_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0;
  int bad = 0;

  logic [15:0] a_data;
  logic [1:0] a_empty, a_rdreq;
  logic a_wr, a_v, a_vwr;
  logic a_ready = 1'b1;
  logic [7:0] a_dout;
  logic [31:0] b_data;
  logic [3:0] b_empty, b_rdreq;
  logic b_wr, b_v, b_vwr;
  logic b_ready = 1'b1;
  logic [7:0] b_dout;
`ifdef UM_EGRESS_CNT_EN
  logic [7:0] a_cnt;
  logic [15:0] b_cnt;
`endif

  um_egress_arb #(.NUM_CH(2), .DATA_W(8), .ARB_MODE(0), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_empty(a_empty), .in_rdreq(a_rdreq),
    .pktout_data_wr(a_wr), .pktout_data(a_dout), .pktout_data_valid(a_v),
    .pktout_data_valid_wr(a_vwr), .pktout_ready(a_ready)
`ifdef UM_EGRESS_CNT_EN
    , .pkt_cnt(a_cnt)
`endif
  );
  um_egress_arb #(.NUM_CH(4), .DATA_W(8), .ARB_MODE(1), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_empty(b_empty), .in_rdreq(b_rdreq),
    .pktout_data_wr(b_wr), .pktout_data(b_dout), .pktout_data_valid(b_v),
    .pktout_data_valid_wr(b_vwr), .pktout_ready(b_ready)
`ifdef UM_EGRESS_CNT_EN
    , .pkt_cnt(b_cnt)
`endif
  );

  // show-ahead FIFO models
  logic [7:0] am [2][64];
  logic [7:0] bm [4][64];
  int awp [2] = '{default: 0};
  int arp [2] = '{default: 0};
  int bwp [4] = '{default: 0};
  int brp [4] = '{default: 0};
  always_comb
    for (int c = 0; c < 2; c++) begin
      a_data[c*8 +: 8] = am[c][arp[c] % 64];
      a_empty[c] = arp[c] == awp[c];
    end
  always_comb
    for (int c = 0; c < 4; c++) begin
      b_data[c*8 +: 8] = bm[c][brp[c] % 64];
      b_empty[c] = brp[c] == bwp[c];
    end
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) if (a_rdreq[c]) arp[c] <= arp[c] + 1;
    for (int c = 0; c < 4; c++) if (b_rdreq[c]) brp[c] <= brp[c] + 1;
  end

  // output logs
  logic [7:0] al_d [256];
  logic al_v [256];
  int al_c [256];
  int an = 0;
  int avc = 0;
  logic [7:0] bl_d [256];
  int bl_c [256];
  int bn = 0;
  always @(negedge clk) begin
    if (a_wr) begin
      al_d[an % 256] <= a_dout;
      al_v[an % 256] <= a_vwr;
      al_c[an % 256] <= cyc;
      an <= an + 1;
    end
    if (a_vwr) avc <= avc + 1;
    if (b_wr) begin
      bl_d[bn % 256] <= b_dout;
      bl_c[bn % 256] <= cyc;
      bn <= bn + 1;
    end
  end

  task automatic push_a(input int c, input logic [7:0] d);
    am[c][awp[c] % 64] = d;
    awp[c] = awp[c] + 1;
  endtask
  task automatic push_b(input int c, input logic [7:0] d);
    bm[c][bwp[c] % 64] = d;
    bwp[c] = bwp[c] + 1;
  endtask

  task automatic test_reset();
    int s;
    push_a(0, 8'hC1);
    repeat (2) @(negedge clk);
    total++;
    if ({a_wr, a_dout, a_v, a_vwr, a_rdreq} !== 12'h0) begin
      bad++; $display("FAIL reset_a got=%h exp=0", {a_wr, a_dout, a_v, a_vwr, a_rdreq});
    end
    total++;
    if ({b_wr, b_dout, b_v, b_vwr, b_rdreq} !== 14'h0) begin
      bad++; $display("FAIL reset_b got=%h exp=0", {b_wr, b_dout, b_v, b_vwr, b_rdreq});
    end
`ifdef UM_EGRESS_CNT_EN
    total++;
    if ({a_cnt, b_cnt} !== 24'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", {a_cnt, b_cnt}); end
`endif
    s = an;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (an - s !== 1 || al_d[s % 256] !== 8'hC1 || al_v[s % 256] !== 1'b1) begin
      bad++; $display("FAIL first_single got n=%0d d=%h vwr=%b exp n=1 d=c1 vwr=1", an - s, al_d[s % 256], al_v[s % 256]);
    end
  endtask

  task automatic test_fixed();
    int s, p;
    logic [7:0] ex [6];
    logic [5:0] ev;
    ex = '{8'h51, 8'h12, 8'h93, 8'h41, 8'h02, 8'h83};
    ev = 6'b100100;
    s = an;
    p = avc;
    push_a(0, 8'h41); push_a(0, 8'h02); push_a(0, 8'h83);
    push_a(1, 8'h51); push_a(1, 8'h12); push_a(1, 8'h93);
    repeat (15) @(negedge clk);
    total++;
    if (an - s !== 6) begin bad++; $display("FAIL fixed_count got=%0d exp=6", an - s); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (al_d[(s + i) % 256] !== ex[i] || al_v[(s + i) % 256] !== ev[i]) begin
        bad++; $display("FAIL fixed_flit%0d got=%h/%b exp=%h/%b", i, al_d[(s + i) % 256], al_v[(s + i) % 256], ex[i], ev[i]);
      end
    end
    total++;
    if (avc - p !== 2) begin bad++; $display("FAIL fixed_tail_pulses got=%0d exp=2", avc - p); end
    total++;
    if (al_c[(s + 2) % 256] - al_c[s % 256] !== 2 || al_c[(s + 3) % 256] - al_c[(s + 2) % 256] !== 2) begin
      bad++; $display("FAIL fixed_spacing got=%0d,%0d exp=2,2", al_c[(s + 2) % 256] - al_c[s % 256], al_c[(s + 3) % 256] - al_c[(s + 2) % 256]);
    end
    total++;
    if (a_v !== 1'b1) begin bad++; $display("FAIL valid_hold got=%b exp=1", a_v); end
  endtask

  task automatic test_rr();
    int s;
    logic [7:0] e;
    s = bn;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) push_b(c, 8'hC0 | 8'(c * 4 + k));
    repeat (30) @(negedge clk);
    total++;
    if (bn - s !== 8) begin bad++; $display("FAIL rr_count got=%0d exp=8", bn - s); end
    for (int i = 0; i < 8; i++) begin
      e = 8'hC0 | 8'((i % 4) * 4 + i / 4);
      total++;
      if (bl_d[(s + i) % 256] !== e) begin bad++; $display("FAIL rr_order%0d got=%h exp=%h", i, bl_d[(s + i) % 256], e); end
    end
    total++;
    if (bl_c[(s + 1) % 256] - bl_c[s % 256] !== 2) begin
      bad++; $display("FAIL rr_gap got=%0d exp=2", bl_c[(s + 1) % 256] - bl_c[s % 256]);
    end
  endtask

  task automatic test_backpressure();
    int s, p;
    logic [7:0] ex [5];
    ex = '{8'h41, 8'h02, 8'h03, 8'h04, 8'h85};
    s = an;
    p = avc;
    for (int i = 0; i < 5; i++) push_a(0, ex[i]);
    repeat (3) @(negedge clk);
    a_ready = 1'b0;
    #1;
    total++;
    if (a_rdreq !== 2'b00) begin bad++; $display("FAIL bp_nopop0 got=%b exp=00", a_rdreq); end
    @(negedge clk);
    total++;
    if (a_rdreq !== 2'b00 || a_wr !== 1'b0) begin bad++; $display("FAIL bp_nopop1 got=%b/%b exp=00/0", a_rdreq, a_wr); end
    @(negedge clk);
    a_ready = 1'b1;
    #1;
    total++;
    if (a_rdreq !== 2'b01) begin bad++; $display("FAIL bp_resume got=%b exp=01", a_rdreq); end
    repeat (10) @(negedge clk);
    total++;
    if (an - s !== 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", an - s); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (al_d[(s + i) % 256] !== ex[i]) begin bad++; $display("FAIL bp_flit%0d got=%h exp=%h", i, al_d[(s + i) % 256], ex[i]); end
    end
    total++;
    if (avc - p !== 1 || al_v[(s + 4) % 256] !== 1'b1) begin
      bad++; $display("FAIL bp_tail got pulses=%0d last=%b exp 1/1", avc - p, al_v[(s + 4) % 256]);
    end
    total++;
    if (al_c[(s + 2) % 256] - al_c[(s + 1) % 256] !== 3) begin
      bad++; $display("FAIL bp_stall got=%0d exp=3", al_c[(s + 2) % 256] - al_c[(s + 1) % 256]);
    end
  endtask

  task automatic test_starve();
    int s;
    logic [7:0] ex [6];
    ex = '{8'h41, 8'h02, 8'h03, 8'h84, 8'h51, 8'h93};
    s = an;
    push_a(0, 8'h41); push_a(0, 8'h02);
    @(negedge clk);
    push_a(1, 8'h51); push_a(1, 8'h93);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (a_rdreq !== 2'b00) begin bad++; $display("FAIL starve_nopop got=%b exp=00", a_rdreq); end
    @(negedge clk);
    total++;
    if (a_rdreq !== 2'b00 || a_wr !== 1'b0) begin bad++; $display("FAIL starve_hold got=%b/%b exp=00/0", a_rdreq, a_wr); end
    repeat (2) @(negedge clk);
    push_a(0, 8'h03); push_a(0, 8'h84);
    repeat (12) @(negedge clk);
    total++;
    if (an - s !== 6) begin bad++; $display("FAIL starve_count got=%0d exp=6", an - s); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (al_d[(s + i) % 256] !== ex[i]) begin bad++; $display("FAIL starve_flit%0d got=%h exp=%h", i, al_d[(s + i) % 256], ex[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    logic [7:0] ex [4];
    ex = '{8'hC7, 8'h04, 8'h05, 8'h86};
    push_a(0, 8'h41); push_a(0, 8'h02); push_a(0, 8'h03);
    push_a(0, 8'h04); push_a(0, 8'h05); push_a(0, 8'h86);
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (a_wr !== 1'b1 || a_dout !== 8'h03) begin bad++; $display("FAIL mid_flit3 got=%b/%h exp=1/03", a_wr, a_dout); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_wr, a_dout, a_v, a_vwr, a_rdreq} !== 12'h0) begin
      bad++; $display("FAIL mid_reset got=%h exp=0", {a_wr, a_dout, a_v, a_vwr, a_rdreq});
    end
    @(negedge clk);
    s = an;
    rst_n = 1'b1;
    push_a(1, 8'hC7);
    repeat (15) @(negedge clk);
    total++;
    if (an - s !== 4) begin bad++; $display("FAIL mid_count got=%0d exp=4", an - s); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (al_d[(s + i) % 256] !== ex[i]) begin bad++; $display("FAIL mid_flit%0d got=%h exp=%h", i, al_d[(s + i) % 256], ex[i]); end
    end
  endtask

`ifdef UM_EGRESS_CNT_EN
  task automatic test_count();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (a_cnt !== 8'h00) begin bad++; $display("FAIL cnt_clear got=%h exp=00", a_cnt); end
    for (int i = 0; i < 17; i++) push_a(0, 8'hC5);
    repeat (61) @(negedge clk);
    total++;
    if (a_cnt[3:0] !== 4'd1) begin bad++; $display("FAIL cnt_wrap got=%0d exp=1", a_cnt[3:0]); end
    total++;
    if (a_cnt[7:4] !== 4'd0) begin bad++; $display("FAIL cnt_ch1 got=%0d exp=0", a_cnt[7:4]); end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed();
    test_rr();
    test_backpressure();
    test_starve();
    test_reset_mid();
`ifdef UM_EGRESS_CNT_EN
    test_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
